// File: rtl/his_peak_finder_pkg.sv
// ============================================================================
// Module   : his_peak_finder_pkg
// Function : Shared constants and FSM state encoding for the histogram peak
//            finder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package his_peak_finder_pkg;

    localparam int DEF_NB      = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_PIX_NUM = 200;
    localparam int DEF_PIX_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } hpf_state_e;

endpackage

`default_nettype wire

// File: rtl/his_peak_finder_if.sv
// ============================================================================
// Module   : his_peak_finder_if
// Function : Control, histogram read port and peak result stream bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface his_peak_finder_if #(
    parameter int NB    = his_peak_finder_pkg::DEF_NB,
    parameter int CNT_W = his_peak_finder_pkg::DEF_CNT_W,
    parameter int PIX_W = his_peak_finder_pkg::DEF_PIX_W
);
    logic             start;
    logic             bank;
    logic [CNT_W-1:0] thresh;

    logic             rd_en;
    logic             rd_bank;
    logic [PIX_W-1:0] rd_pix;
    logic [NB-1:0]    rd_bin;
    logic [CNT_W-1:0] rd_data;

    logic             peak_valid;
    logic             peak_ready;
    logic [PIX_W-1:0] peak_pix;
    logic [NB-1:0]    peak_bin;
    logic [CNT_W-1:0] peak_cnt;
    logic             peak_hit;

    logic             busy;
    logic             done;
    logic             overrun;

    modport master (
        output start, bank, thresh, rd_data, peak_ready,
        input  rd_en, rd_bank, rd_pix, rd_bin,
        input  peak_valid, peak_pix, peak_bin, peak_cnt, peak_hit,
        input  busy, done, overrun
    );

    modport slave (
        input  start, bank, thresh, rd_data, peak_ready,
        output rd_en, rd_bank, rd_pix, rd_bin,
        output peak_valid, peak_pix, peak_bin, peak_cnt, peak_hit,
        output busy, done, overrun
    );

endinterface

`default_nettype wire

// File: rtl/his_max_tracker.sv
// ============================================================================
// Module   : his_max_tracker
// Function : Running maximum / argmax over a stream of bin counts; the lowest
//            bin index wins on ties.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module his_max_tracker
    import his_peak_finder_pkg::*;
#(
    parameter int NB    = DEF_NB,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             init_i,
    input  logic             valid_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic [NB-1:0]    bin_i,
    output logic [CNT_W-1:0] max_cnt_o,
    output logic [NB-1:0]    max_bin_o
);

    logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
    logic [NB-1:0]    max_bin_q, max_bin_d;

    // Strictly-greater update keeps the earliest bin on equal counts.
    always_comb begin
        max_cnt_d = max_cnt_q;
        max_bin_d = max_bin_q;
        if (valid_i && (init_i || (data_i > max_cnt_q))) begin
            max_cnt_d = data_i;
            max_bin_d = bin_i;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            max_cnt_q <= '0;
            max_bin_q <= '0;
        end else begin
            max_cnt_q <= max_cnt_d;
            max_bin_q <= max_bin_d;
        end
    end

    assign max_cnt_o = max_cnt_q;
    assign max_bin_o = max_bin_q;

endmodule

`default_nettype wire

// File: rtl/his_peak_finder.sv
// ============================================================================
// Module   : his_peak_finder
// Function : Scans a completed histogram bank pixel by pixel and streams the
//            peak bin, its count and a threshold hit flag for every pixel.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module his_peak_finder
    import his_peak_finder_pkg::*;
#(
    parameter int NB      = DEF_NB,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PIX_NUM = DEF_PIX_NUM,
    parameter int PIX_W   = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             res,
    his_peak_finder_if.slave bus
);

    localparam int               NBINS    = 2 ** NB;
    localparam logic [NB-1:0]    LAST_BIN = NB'(NBINS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_NUM - 1);

    hpf_state_e       state_q, state_d;
    logic [NB-1:0]    bin_q, bin_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             bank_q, bank_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic             overrun_q, overrun_d;

    // Read request delayed by one cycle to line up with the returning data.
    logic             rvld_q;
    logic [NB-1:0]    rbin_q;

    logic [CNT_W-1:0] max_cnt;
    logic [NB-1:0]    max_bin;
    logic             rd_en_w;
    logic             emit_w;
    logic             accept_w;

    assign rd_en_w  = (state_q == ST_READ);
    assign emit_w   = (state_q == ST_EMIT);
    assign accept_w = emit_w && bus.peak_ready;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        pix_d     = pix_q;
        bank_d    = bank_q;
        thresh_d  = thresh_q;
        overrun_d = overrun_q | (bus.start && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bank_d   = bus.bank;
                    thresh_d = bus.thresh;
                    pix_d    = '0;
                    bin_d    = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                bin_d = bin_q + 1'b1;
                if (bin_q == LAST_BIN) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (accept_w) begin
                    if (pix_q < LAST_PIX) begin
                        pix_d   = pix_q + 1'b1;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            pix_q     <= '0;
            bank_q    <= 1'b0;
            thresh_q  <= '0;
            overrun_q <= 1'b0;
            rvld_q    <= 1'b0;
            rbin_q    <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            pix_q     <= pix_d;
            bank_q    <= bank_d;
            thresh_q  <= thresh_d;
            overrun_q <= overrun_d;
            rvld_q    <= rd_en_w;
            rbin_q    <= bin_q;
        end
    end

    his_max_tracker #(
        .NB    (NB),
        .CNT_W (CNT_W)
    ) u_max (
        .clk       (clk),
        .res       (res),
        .init_i    (rvld_q && (rbin_q == '0)),
        .valid_i   (rvld_q),
        .data_i    (bus.rd_data),
        .bin_i     (rbin_q),
        .max_cnt_o (max_cnt),
        .max_bin_o (max_bin)
    );

    // Address and result buses are forced to zero outside their active state.
    assign bus.rd_en      = rd_en_w;
    assign bus.rd_bank    = rd_en_w && bank_q;
    assign bus.rd_pix     = rd_en_w ? pix_q : '0;
    assign bus.rd_bin     = rd_en_w ? bin_q : '0;

    assign bus.peak_valid = emit_w;
    assign bus.peak_pix   = emit_w ? pix_q   : '0;
    assign bus.peak_bin   = emit_w ? max_bin : '0;
    assign bus.peak_cnt   = emit_w ? max_cnt : '0;
    assign bus.peak_hit   = emit_w && (max_cnt >= thresh_q);

    assign bus.busy       = (state_q == ST_READ) || (state_q == ST_DRAIN) || emit_w;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_his_peak_finder.sv
// ============================================================================
// Module   : tb_his_peak_finder
// Function : Self-checking bench for his_peak_finder with a histogram memory
//            model and a max/argmax reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_his_peak_finder;

    localparam int NB      = 4;
    localparam int NBINS   = 16;
    localparam int CNT_W   = 16;
    localparam int PIX_NUM = 3;
    localparam int PIX_W   = 8;
    localparam int RW      = PIX_W + NB + CNT_W + 1;

    logic clk = 1'b0;
    logic res;
    int   checks   = 0;
    int   failures = 0;

    logic [CNT_W-1:0] hist [2][PIX_NUM][NBINS];

    his_peak_finder_if #(.NB(NB), .CNT_W(CNT_W), .PIX_W(PIX_W)) bus ();

    his_peak_finder #(
        .NB      (NB),
        .CNT_W   (CNT_W),
        .PIX_NUM (PIX_NUM),
        .PIX_W   (PIX_W)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous histogram memory; junk is returned when not reading.
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1 && int'(bus.rd_pix) < PIX_NUM)
            bus.rd_data <= hist[bus.rd_bank][int'(bus.rd_pix)][bus.rd_bin];
        else
            bus.rd_data <= 16'hDEAD;
    end

    // Reference: largest count, then the first bin holding that count.
    function automatic void ref_peak(input int bk, input int px, output int pbin, output int pcnt);
        int mx;
        mx = 0;
        for (int b = 0; b < NBINS; b++)
            if (int'(hist[bk][px][b]) > mx) mx = int'(hist[bk][px][b]);
        pbin = -1;
        for (int b = 0; b < NBINS; b++)
            if (pbin < 0 && int'(hist[bk][px][b]) == mx) pbin = b;
        pcnt = mx;
    endfunction

    function automatic logic [RW-1:0] got_peak();
        return {bus.peak_pix, bus.peak_bin, bus.peak_cnt, bus.peak_hit};
    endfunction

    function automatic logic [RW-1:0] exp_peak(input int p, input int eb, input int ec, input int th);
        return {PIX_W'(p), NB'(eb), CNT_W'(ec), 1'(ec >= th)};
    endfunction

    task automatic fill_bank(input int bk, input int maxv, input bit allow_zero);
        for (int p = 0; p < PIX_NUM; p++) begin
            bit z;
            z = allow_zero && ($urandom_range(0, 3) == 0);
            for (int b = 0; b < NBINS; b++)
                hist[bk][p][b] = z ? '0 : CNT_W'($urandom_range(0, maxv));
        end
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (bus.peak_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.peak_valid === 1'b1);
    endtask

    // Called at a negedge; returns at the following negedge with start low.
    task automatic do_start(input int bk, input int th);
        bus.start  = 1'b1;
        bus.bank   = 1'(bk);
        bus.thresh = CNT_W'(th);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bank   = ~bus.bank;
        bus.thresh = CNT_W'($urandom);
    endtask

    task automatic test_reset();
        res = 1'b1;
        bus.start = 1'b0; bus.bank = 1'b0; bus.thresh = '0; bus.peak_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rd_en, bus.rd_bank, bus.rd_pix, bus.rd_bin} !== '0) begin
            failures++;
            $display("FAIL reset_rd: got %h expected 0", {bus.rd_en, bus.rd_bank, bus.rd_pix, bus.rd_bin});
        end
        checks++;
        if ({bus.peak_valid, got_peak()} !== '0) begin
            failures++;
            $display("FAIL reset_peak: got %h expected 0", {bus.peak_valid, got_peak()});
        end
        checks++;
        if ({bus.busy, bus.done, bus.overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.done, bus.overrun});
        end
        res = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_peak();
        int  cyc;
        bit  ok;
        int  e_bin [PIX_NUM] = '{9, 3, 0};
        int  e_cnt [PIX_NUM] = '{40, 25, 0};
        for (int p = 0; p < PIX_NUM; p++)
            for (int b = 0; b < NBINS; b++)
                hist[0][p][b] = (p == 0) ? 16'd1 : 16'd0;
        hist[0][0][9]  = 16'd40;
        hist[0][1][3]  = 16'd25;
        hist[0][1][12] = 16'd25;
        bus.peak_ready = 1'b1;
        do_start(0, 10);
        cyc = 1;
        while (bus.peak_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != NBINS + 2) begin
            failures++;
            $display("FAIL first_latency: got %0d cycles expected %0d", cyc, NBINS + 2);
        end
        for (int p = 0; p < PIX_NUM; p++) begin
            wait_valid(ok);
            checks++;
            if (!ok || got_peak() !== exp_peak(p, e_bin[p], e_cnt[p], 10)) begin
                failures++;
                $display("FAIL plan_pixel%0d: got %h expected %h", p, got_peak(), exp_peak(p, e_bin[p], e_cnt[p], 10));
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL done_pulse: got done,busy=%b expected 10", {bus.done, bus.busy});
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy, bus.peak_valid} !== 3'b000) begin
            failures++;
            $display("FAIL after_done: got done,busy,valid=%b expected 000", {bus.done, bus.busy, bus.peak_valid});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int eb, ec, th;
        logic [RW-1:0] snap;
        fill_bank(1, 30, 1'b0);
        th = $urandom_range(0, 30);
        bus.peak_ready = 1'b0;
        do_start(1, th);
        wait_valid(ok);
        ref_peak(1, 0, eb, ec);
        checks++;
        if (!ok || got_peak() !== exp_peak(0, eb, ec, th)) begin
            failures++;
            $display("FAIL bp_pixel0: got %h expected %h", got_peak(), exp_peak(0, eb, ec, th));
        end
        snap = exp_peak(0, eb, ec, th);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.peak_valid, bus.rd_en} !== 2'b10 || got_peak() !== snap) begin
                failures++;
                $display("FAIL bp_stall%0d: got valid,rd_en=%b peak=%h expected 10 %h", k, {bus.peak_valid, bus.rd_en}, got_peak(), snap);
            end
        end
        bus.peak_ready = 1'b1;
        @(negedge clk);
        for (int b = 0; b < NBINS; b++) begin
            checks++;
            if ({bus.rd_en, bus.rd_bank, bus.rd_pix, bus.rd_bin} !== {1'b1, 1'b1, PIX_W'(1), NB'(b)}) begin
                failures++;
                $display("FAIL bp_read%0d: got %h expected %h", b, {bus.rd_en, bus.rd_bank, bus.rd_pix, bus.rd_bin}, {1'b1, 1'b1, PIX_W'(1), NB'(b)});
            end
            @(negedge clk);
        end
        for (int p = 1; p < PIX_NUM; p++) begin
            wait_valid(ok);
            ref_peak(1, p, eb, ec);
            checks++;
            if (!ok || got_peak() !== exp_peak(p, eb, ec, th)) begin
                failures++;
                $display("FAIL bp_pixel%0d: got %h expected %h", p, got_peak(), exp_peak(p, eb, ec, th));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: got %b expected 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int idx, eb, ec, badbank;
        bit pulsed, seen_done;
        fill_bank(0, 60, 1'b0);
        fill_bank(1, 60, 1'b0);
        bus.peak_ready = 1'b1;
        do_start(0, 65535);
        idx = 0; badbank = 0; pulsed = 1'b0; seen_done = 1'b0;
        for (int n = 0; n < 1000 && !seen_done; n++) begin
            if (bus.rd_en === 1'b1 && bus.rd_bank !== 1'b0) badbank++;
            if (bus.peak_valid === 1'b1) begin
                if (idx < PIX_NUM) ref_peak(0, idx, eb, ec);
                checks++;
                if (idx >= PIX_NUM || got_peak() !== exp_peak(idx, eb, ec, 65535)) begin
                    failures++;
                    $display("FAIL ovr_result%0d: got %h expected %h", idx, got_peak(), exp_peak(idx, eb, ec, 65535));
                end
                idx++;
            end
            if (bus.done === 1'b1) seen_done = 1'b1;
            if (!pulsed && bus.rd_en === 1'b1 && bus.rd_pix == 1 && bus.rd_bin == 5) begin
                bus.start = 1'b1; bus.bank = 1'b1; bus.thresh = '0;
                pulsed = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (!seen_done || idx != PIX_NUM) begin
            failures++;
            $display("FAIL ovr_scan: got done=%0d results=%0d expected 1 %0d", seen_done, idx, PIX_NUM);
        end
        checks++;
        if (badbank != 0) begin
            failures++;
            $display("FAIL ovr_bank: got %0d bank-1 reads expected 0", badbank);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.overrun, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL ovr_sticky: got overrun,busy=%b expected 10", {bus.overrun, bus.busy});
        end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_reset_midscan();
        int n, bad, eb, ec, th;
        bit ok;
        fill_bank(0, 40, 1'b1);
        fill_bank(1, 40, 1'b1);
        bus.peak_ready = 1'b1;
        do_start(0, 7);
        n = 0;
        while (!(bus.rd_en === 1'b1 && bus.rd_pix == 1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL rst_reach_pix1: got timeout expected pixel 1 read");
        end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.peak_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_abort: got %0d active cycles expected 0", bad);
        end
        th = $urandom_range(0, 40);
        do_start(1, th);
        checks++;
        if ({bus.rd_en, bus.rd_bank, bus.rd_pix} !== {1'b1, 1'b1, PIX_W'(0)}) begin
            failures++;
            $display("FAIL rst_restart: got %h expected %h", {bus.rd_en, bus.rd_bank, bus.rd_pix}, {1'b1, 1'b1, PIX_W'(0)});
        end
        for (int p = 0; p < PIX_NUM; p++) begin
            wait_valid(ok);
            ref_peak(1, p, eb, ec);
            checks++;
            if (!ok || got_peak() !== exp_peak(p, eb, ec, th)) begin
                failures++;
                $display("FAIL rst_pixel%0d: got %h expected %h", p, got_peak(), exp_peak(p, eb, ec, th));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL rst_done: got %b expected 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            int bk, th, idx, eb, ec, stab_bad;
            bit seen_done, hold;
            logic [RW-1:0] prev;
            fill_bank(0, 20, 1'b1);
            fill_bank(1, 20, 1'b1);
            bk = $urandom_range(0, 1);
            th = (s == 0) ? 0 : $urandom_range(0, 20);
            idx = 0; stab_bad = 0; seen_done = 1'b0; hold = 1'b0; prev = '0;
            bus.peak_ready = 1'b1;
            do_start(bk, th);
            for (int n = 0; n < 2000 && !seen_done; n++) begin
                if (bus.peak_valid === 1'b1) begin
                    if (hold && got_peak() !== prev) stab_bad++;
                    if (bus.peak_ready) begin
                        if (idx < PIX_NUM) ref_peak(bk, idx, eb, ec);
                        checks++;
                        if (idx >= PIX_NUM || got_peak() !== exp_peak(idx, eb, ec, th)) begin
                            failures++;
                            $display("FAIL rnd%0d_pixel%0d: got %h expected %h", s, idx, got_peak(), exp_peak(idx, eb, ec, th));
                        end
                        idx++;
                    end
                    prev = got_peak();
                    hold = !bus.peak_ready;
                end else begin
                    hold = 1'b0;
                end
                if (bus.done === 1'b1) seen_done = 1'b1;
                @(negedge clk);
                bus.peak_ready = ($urandom_range(0, 3) != 0);
            end
            checks++;
            if (!seen_done || idx != PIX_NUM || stab_bad != 0) begin
                failures++;
                $display("FAIL rnd%0d_scan: got done=%0d results=%0d unstable=%0d expected 1 %0d 0", s, seen_done, idx, stab_bad, PIX_NUM);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_backpressure();
        test_overrun();
        test_reset_midscan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/his_peak_finder.md
Name: his_peak_finder

Overview:
- Downstream neighbour of the histogram builder in the dToF pipeline.
- When the builder signals that a histogram bank is complete (acq_count_finish pulse plus hisNum bank select), this block scans that bank one pixel at a time.
- For each pixel it reads every bin through a synchronous read port and finds the maximum-count bin (the ToF peak).
- It emits one result per pixel on a valid/ready stream to the depth-calculation stage.

Parameters:
- NB, 8: bin address width; the bin count is NBINS = 2**NB.
- CNT_W, 16: width of one histogram bin count.
- PIX_NUM, 200: pixels per histogram bank.
- PIX_W, 8: pixel index width; PIX_W must satisfy 2**PIX_W >= PIX_NUM.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: bank complete (from acq_count_finish).
- bank  in  1  bank to scan (from hisNum); sampled only when start is accepted.
- thresh  in  CNT_W  minimum count for a pixel's peak to be valid; sampled when start is accepted.
- rd_en  out  1  histogram read strobe.
- rd_bank  out  1  bank being read.
- rd_pix  out  PIX_W  pixel address.
- rd_bin  out  NB  bin address.
- rd_data  in  CNT_W  bin count; valid exactly 1 cycle after rd_en.
- peak_valid  out  1  result valid.
- peak_ready  in  1  consumer accept.
- peak_pix  out  PIX_W  pixel index of the result.
- peak_bin  out  NB  bin index of the maximum count.
- peak_cnt  out  CNT_W  maximum count.
- peak_hit  out  1  1 if peak_cnt >= thresh (captured value).
- busy  out  1  high from the accepted start until done.
- done  out  1  1-cycle pulse after the last pixel's result is accepted.
- overrun  out  1  sticky; set when start arrives while busy.

Behaviour:
- Reset (res=1 at a clk edge): FSM goes to IDLE.
  - All outputs go to 0, including overrun, rd_* and peak_*.
  - Reset mid-scan aborts the scan immediately and produces no done pulse.
- FSM states: IDLE, READ, DRAIN, EMIT, DONE.
- IDLE:
  - start=1 latches bank and thresh, clears the pixel counter, asserts busy, and moves to READ next cycle.
- READ:
  - Issues rd_en=1 with rd_bin = 0..NBINS-1 on consecutive cycles, one bin per cycle, with no gaps.
  - rd_pix holds the current pixel and rd_bank holds the latched bank.
  - After bin NBINS-1 is issued, moves to DRAIN.
- Compare datapath:
  - Data returning for bin 0 initialises max_cnt and max_bin unconditionally.
  - For later bins, update only when rd_data > max_cnt (strictly greater). On ties the lowest bin index wins.
- DRAIN:
  - One cycle, rd_en=0. The final data word is compared.
  - Moves to EMIT.
- EMIT:
  - peak_valid=1 with peak_pix, peak_bin, peak_cnt and peak_hit (max_cnt >= thresh).
  - All peak_* outputs stay stable until peak_valid & peak_ready.
  - rd_en=0 while in EMIT.
  - On the handshake: if pixel < PIX_NUM-1, increment the pixel and go to READ; otherwise go to DONE.
- DONE:
  - done=1 for one cycle, busy drops, and the FSM returns to IDLE.
  - peak_valid falls on the cycle after the handshake.
- Timing with peak_ready held high:
  - Each pixel takes NBINS+2 cycles.
  - Pixel 0's first result appears NBINS+2 cycles after the start edge.
- Start while busy (any state other than IDLE): ignored; overrun set to 1 and held until res. A start in the same cycle as done is also ignored and also sets overrun.
- All-zero pixel histogram: peak_bin=0, peak_cnt=0, peak_hit=(thresh==0).
- thresh=0 means every pixel hits.
- Arithmetic: unsigned compares only, no saturation needed. The bin counter wraps naturally at NBINS; the terminal test uses bin==NBINS-1.
- Backpressure: peak_ready low stalls in EMIT indefinitely, with no reads and no loss of data.

Decomposition:
- Shared package/header (alongside parametersSiFH.vh):
  - constants NB, CNT_W, PIX_NUM, PIX_W;
  - FSM state encodings (3-bit).
- One sub-module, his_max_tracker: the running max/argmax register pair, with inputs init, valid, data and bin, and outputs max_cnt and max_bin. It handles the strict-greater and tie rule, so it can be unit-tested on its own.

Test Plan (NB=4, NBINS=16, PIX_NUM=3, CNT_W=16):
- Single peak: pixel 0 bins all 1 except bin 9 = 40, thresh=10, ready high.
  - Expect peak_pix=0, peak_bin=9, peak_cnt=40, peak_hit=1.
  - peak_valid rises 18 cycles after start.
- Tie: pixel 1 has bin 3 = 25 and bin 12 = 25, all other bins 0.
  - Expect peak_bin=3, peak_cnt=25.
- Below threshold / empty: pixel 2 all zeros, thresh=10.
  - Expect peak_bin=0, peak_cnt=0, peak_hit=0.
  - done pulses 1 cycle after the third handshake and busy goes low.
- Backpressure: hold peak_ready=0 for 7 cycles on pixel 0.
  - Expect peak_* stable, rd_en=0 throughout, and the pixel 1 reads starting the cycle after ready rises.
- Overrun: pulse start mid-READ of pixel 1.
  - Expect overrun=1 and the scan continues unchanged with bank unchanged.
  - overrun stays 1 after done; it clears only on res.
- Reset mid-scan: assert res during READ of pixel 1, then start with bank=1.
  - Expect no done pulse from the aborted scan.
  - Expect rd_bank=1 and results restarting at peak_pix=0.
